// File: rtl/alu_pkg.sv
// Shared ALU op encodings ({funct7[5], funct3}) and the legality check used by
// the arbiter's response slots.
package alu_pkg;

  localparam int OPW = 4;

  localparam logic [OPW-1:0] OP_ADD  = 4'b0000;
  localparam logic [OPW-1:0] OP_SUB  = 4'b1000;
  localparam logic [OPW-1:0] OP_SLL  = 4'b0001;
  localparam logic [OPW-1:0] OP_SLT  = 4'b0010;
  localparam logic [OPW-1:0] OP_SLTU = 4'b0011;
  localparam logic [OPW-1:0] OP_XOR  = 4'b0100;
  localparam logic [OPW-1:0] OP_SRL  = 4'b0101;
  localparam logic [OPW-1:0] OP_SRA  = 4'b1101;
  localparam logic [OPW-1:0] OP_OR   = 4'b0110;
  localparam logic [OPW-1:0] OP_AND  = 4'b0111;

  function automatic logic op_is_legal(input logic [OPW-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
      OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_rsp_slot.sv
// One-entry response buffer: loads the ALU result on a grant, holds it until the
// consumer takes it; unsupported ops load a zero result with the error flag set.
module alu_rsp_slot
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [OPW-1:0]   i_op,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_out,
  output logic             o_err
);

  logic             r_valid;
  logic [WIDTH-1:0] r_out;
  logic             r_err;
  logic             w_legal;

  assign w_legal = op_is_legal(i_op);

  // A load in the same cycle as a drain wins, so the slot simply reloads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_out   <= '0;
      r_err   <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_out   <= w_legal ? i_din : '0;
      r_err   <= !w_legal;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_out   = r_out;
  assign o_err   = r_err;

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter letting two requesters share one combinational ALU, with a
// per-requester response slot and a saturating contention counter.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = alu_pkg::OPW,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_out,
  output logic             rsp0_err,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_out,
  output logic             rsp1_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_out,
  output logic [CNTW-1:0]  conflict_cnt
);

  import alu_pkg::*;

  logic [1:0]       w_req_valid;
  logic [1:0]       w_rsp_ready;
  logic [1:0]       w_rsp_valid;
  logic [1:0]       w_rsp_err;
  logic [WIDTH-1:0] w_rsp_out [2];
  logic [1:0]       w_elig;
  logic [1:0]       w_grant;
  logic             r_last_grant;
  logic [CNTW-1:0]  r_conflict_cnt;

  assign w_req_valid = {req1_valid, req0_valid};
  assign w_rsp_ready = {rsp1_ready, rsp0_ready};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      // No handshake is offered while reset is asserted.
      assign w_elig[gi] = rst_n && w_req_valid[gi] && (!w_rsp_valid[gi] || w_rsp_ready[gi]);

      alu_rsp_slot #(.WIDTH(WIDTH)) u_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_grant[gi]),
        .i_op    (alu_op),
        .i_din   (alu_out),
        .i_ready (w_rsp_ready[gi]),
        .o_valid (w_rsp_valid[gi]),
        .o_out   (w_rsp_out[gi]),
        .o_err   (w_rsp_err[gi])
      );
    end
  endgenerate

  // On a tie, the requester that was not granted last wins.
  assign w_grant[0] = w_elig[0] && (!w_elig[1] || r_last_grant);
  assign w_grant[1] = w_elig[1] && (!w_elig[0] || !r_last_grant);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
    end else if (w_grant[0]) begin
      r_last_grant <= 1'b0;
    end else if (w_grant[1]) begin
      r_last_grant <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_conflict_cnt <= '0;
    end else if (w_elig == 2'b11 && r_conflict_cnt != '1) begin
      r_conflict_cnt <= r_conflict_cnt + 1'b1;
    end
  end

  assign alu_a  = w_grant[0] ? req0_a  : (w_grant[1] ? req1_a  : '0);
  assign alu_b  = w_grant[0] ? req0_b  : (w_grant[1] ? req1_b  : '0);
  assign alu_op = w_grant[0] ? req0_op : (w_grant[1] ? req1_op : '0);

  assign req0_ready   = w_grant[0];
  assign req1_ready   = w_grant[1];
  assign rsp0_valid   = w_rsp_valid[0];
  assign rsp1_valid   = w_rsp_valid[1];
  assign rsp0_out     = w_rsp_out[0];
  assign rsp1_out     = w_rsp_out[1];
  assign rsp0_err     = w_rsp_err[0];
  assign rsp1_err     = w_rsp_err[1];
  assign conflict_cnt = r_conflict_cnt;

endmodule
